muldiv_unit: RTL



---
 rtl/cpu_defs.sv | 22 ++
 rtl/muldiv_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_defs.sv
// Shared RV32M definitions: funct3 encodings, the M-extension funct7 selector
// and the multiply/divide unit state encoding.
package cpu_defs;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CALC   = 2'd1,
      ST_FINISH = 2'd2
   } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// on operand magnitudes, with sign correction applied in the FINISH cycle.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | waiting for i_start; o_busy low
//   ST_CALC   | one multiply/divide iteration per cycle, counter 0..31
//   ST_FINISH | sign correction, result registered, o_valid next cycle
module muldiv_unit
   import cpu_defs::*;
#(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start,
   input  logic            i_kill,
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_in_a,
   input  logic [XLEN-1:0] i_in_b,
   output logic            o_busy,
   output logic            o_valid,
   output logic [XLEN-1:0] o_result
);

   localparam int CNT_W = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   md_state_e         state_q, state_d;
   logic [2:0]        f3_q, f3_d;
   logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              neg_q, neg_d, sa_q, sa_d, special_q, special_d;
   logic              valid_q, valid_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              sign_a_in, sign_b_in, neg_a_in, neg_b_in;
   logic [CNT_W-1:0]  bit_idx;
   logic [XLEN:0]     div_rs;
   logic              div_ge;
   logic [XLEN-1:0]   div_sub;
   logic [2*XLEN-1:0] mul_add, prod;
   logic [XLEN-1:0]   quot, rem, fin_result;

   assign sign_a_in = (i_funct3 != F3_MULHU) && (i_funct3 != F3_DIVU) && (i_funct3 != F3_REMU);
   assign sign_b_in = (i_funct3 == F3_MUL) || (i_funct3 == F3_MULH) ||
                      (i_funct3 == F3_DIV) || (i_funct3 == F3_REM);
   assign neg_a_in  = sign_a_in && i_in_a[XLEN-1];
   assign neg_b_in  = sign_b_in && i_in_b[XLEN-1];

   // Restoring divide: remainder lives in acc[63:32], quotient shifts into acc[31:0].
   assign bit_idx = CNT_W'(XLEN-1) - cnt_q;
   assign div_rs  = {acc_q[2*XLEN-1:XLEN], a_q[bit_idx]};
   assign div_ge  = div_rs >= {1'b0, b_q};
   assign div_sub = div_rs[XLEN-1:0] - b_q;
   assign mul_add = b_q[cnt_q] ? ({{XLEN{1'b0}}, a_q} << cnt_q) : '0;

   assign prod = neg_q ? (~acc_q + 1'b1) : acc_q;
   assign quot = abs_val(acc_q[XLEN-1:0], neg_q);
   assign rem  = abs_val(acc_q[2*XLEN-1:XLEN], sa_q);

   always_comb begin
      fin_result = '0;
      if (special_q) begin
         fin_result = acc_q[XLEN-1:0];
      end else begin
         case (f3_q)
            F3_MUL:                       fin_result = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fin_result = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fin_result = quot;
            default:                      fin_result = rem;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      f3_d      = f3_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      sa_d      = sa_q;
      special_d = special_q;
      valid_d   = 1'b0;
      result_d  = result_q;
      case (state_q)
         ST_IDLE: begin
            if (i_start && !i_kill) begin
               f3_d      = i_funct3;
               a_d       = abs_val(i_in_a, neg_a_in);
               b_d       = abs_val(i_in_b, neg_b_in);
               neg_d     = neg_a_in ^ neg_b_in;
               sa_d      = neg_a_in;
               acc_d     = '0;
               cnt_d     = '0;
               special_d = 1'b0;
               state_d   = ST_CALC;
               // Special divide results are parked in acc[31:0] and skip CALC.
               if (i_funct3[2] && (i_in_b == '0)) begin
                  special_d             = 1'b1;
                  acc_d[XLEN-1:0]       = i_funct3[1] ? i_in_a : '1;
                  state_d               = ST_FINISH;
               end else if ((i_funct3 == F3_DIV || i_funct3 == F3_REM) &&
                            (i_in_a == MIN_NEG) && (i_in_b == '1)) begin
                  special_d             = 1'b1;
                  acc_d[XLEN-1:0]       = i_funct3[1] ? '0 : MIN_NEG;
                  state_d               = ST_FINISH;
               end
            end
         end
         ST_CALC: begin
            if (f3_q[2]) begin
               acc_d = div_ge ? {div_sub, acc_q[XLEN-2:0], 1'b1}
                              : {div_rs[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end else begin
               acc_d = acc_q + mul_add;
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(XLEN-1)) begin
               state_d = ST_FINISH;
            end
         end
         ST_FINISH: begin
            state_d  = ST_IDLE;
            valid_d  = 1'b1;
            result_d = fin_result;
         end
         default: state_d = ST_IDLE;
      endcase
      if (i_kill) begin
         state_d  = ST_IDLE;
         valid_d  = 1'b0;
         result_d = result_q;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         f3_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         sa_q      <= 1'b0;
         special_q <= 1'b0;
         valid_q   <= 1'b0;
         result_q  <= '0;
      end else begin
         f3_q      <= f3_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
         sa_q      <= sa_d;
         special_q <= special_d;
         valid_q   <= valid_d;
         result_q  <= result_d;
      end
   end

   assign o_busy   = (state_q != ST_IDLE);
   assign o_valid  = valid_q;
   assign o_result = result_q;

endmodule
